// File: rtl/reg_desp_pkg.sv
// Shared constants for the universal shift register: mode and direction
// codes plus the state encoding of the multi-step engine.
package reg_desp_pkg;

    localparam logic [1:0] MODO_SERIE   = 2'b00;
    localparam logic [1:0] MODO_ROTA    = 2'b01;
    localparam logic [1:0] MODO_CARGA   = 2'b10;
    localparam logic [1:0] MODO_RETENER = 2'b11;

    localparam logic DIR_IZQ = 1'b0;
    localparam logic DIR_DER = 1'b1;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        OCUPADO  = 2'd1,
        LISTO    = 2'd2
    } estado_t;

endpackage

// File: rtl/celda_desplazamiento.sv
// One bit of the shift register. The top level decides what the end cells
// see as neighbours, so shift and rotate look identical here.
module celda_desplazamiento
    import reg_desp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enb,
    input  logic       vec_izq,
    input  logic       vec_der,
    input  logic       d_n,
    input  logic [1:0] modo,
    input  logic       dir,
    output logic       q_n
);

    logic sig;

    // next value of this bit for the selected mode and direction
    always_comb begin
        sig = q_n;
        case (modo)
            MODO_SERIE, MODO_ROTA: sig = (dir == DIR_DER) ? vec_izq : vec_der;
            MODO_CARGA:            sig = d_n;
            default:               sig = q_n;
        endcase
    end

    // bit storage, updated only on enabled edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q_n <= 1'b0;
        else if (enb)
            q_n <= sig;
    end

endmodule

// File: rtl/registro_desplazamiento.sv
// Parametrised universal shift register (shift, rotate, load, hold).
// Optional multi-step engine enabled by defining REG_DESP_MULTIPASO_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INACTIVO | idle; single-step behaviour, waits for a start request
// OCUPADO  | multi-step run in progress, one step per enabled edge
// LISTO    | run finished; done high for one enabled cycle, q holds
module registro_desplazamiento
    import reg_desp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [1:0]       modo,
    input  logic             dir,
    input  logic             s_der,
    input  logic             s_izq,
    input  logic [WIDTH-1:0] d,
`ifdef REG_DESP_MULTIPASO_EN
    input  logic             start,
    input  logic [CW-1:0]    cant,
`endif
    output logic [WIDTH-1:0] q,
    output logic             s_out,
    output logic             busy,
    output logic             done
);

    logic [1:0] modo_ef;
    logic       dir_ef;
    logic       en_paso;
    logic       fin_der;
    logic       fin_izq;

`ifdef REG_DESP_MULTIPASO_EN
    estado_t       estado, estado_sig;
    logic [CW-1:0] rest, rest_sig;
    logic [1:0]    modo_l;
    logic          dir_l;
    logic          arranque;

    assign arranque = (estado == INACTIVO) && start &&
                      ((modo == MODO_SERIE) || (modo == MODO_ROTA));

    // next state, step counter and the mode/direction/enable seen by the cells
    always_comb begin
        estado_sig = estado;
        rest_sig   = rest;
        modo_ef    = modo;
        dir_ef     = dir;
        en_paso    = enb;
        case (estado)
            INACTIVO: begin
                if (arranque) begin
                    if (cant == '0) begin
                        en_paso    = 1'b0;
                        rest_sig   = '0;
                        estado_sig = LISTO;
                    end else if (cant == CW'(1)) begin
                        estado_sig = LISTO;
                    end else begin
                        rest_sig   = cant - CW'(1);
                        estado_sig = OCUPADO;
                    end
                end
            end
            OCUPADO: begin
                modo_ef  = modo_l;
                dir_ef   = dir_l;
                rest_sig = rest - CW'(1);
                if (rest == CW'(1))
                    estado_sig = LISTO;
            end
            LISTO: begin
                en_paso    = 1'b0;
                estado_sig = INACTIVO;
            end
            default: begin
                en_paso    = 1'b0;
                estado_sig = INACTIVO;
            end
        endcase
    end

    // engine state and step counter; a disabled edge freezes both
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= INACTIVO;
            rest   <= '0;
        end else if (enb) begin
            estado <= estado_sig;
            rest   <= rest_sig;
        end
    end

    // capture the requested operation so later input changes cannot disturb it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            modo_l <= MODO_SERIE;
            dir_l  <= DIR_IZQ;
        end else if (enb && arranque) begin
            modo_l <= modo;
            dir_l  <= dir;
        end
    end

    assign busy = (estado == OCUPADO);
    assign done = (estado == LISTO);
`else
    assign modo_ef = modo;
    assign dir_ef  = dir;
    assign en_paso = enb;
    assign busy    = 1'b0;
    assign done    = 1'b0;
`endif

    // end bits: serial inputs for a shift, the opposite end bit for a rotate
    assign fin_der = (modo_ef == MODO_ROTA) ? q[WIDTH-1] : s_der;
    assign fin_izq = (modo_ef == MODO_ROTA) ? q[0]       : s_izq;

    for (genvar i = 0; i < WIDTH; i++) begin : g_celda
        logic v_izq;
        logic v_der;

        if (i == WIDTH - 1) begin : g_msb
            assign v_izq = fin_izq;
        end else begin : g_int_izq
            assign v_izq = q[i+1];
        end

        if (i == 0) begin : g_lsb
            assign v_der = fin_der;
        end else begin : g_int_der
            assign v_der = q[i-1];
        end

        celda_desplazamiento u_celda (
            .clk     (clk),
            .reset   (reset),
            .enb     (en_paso),
            .vec_izq (v_izq),
            .vec_der (v_der),
            .d_n     (d[i]),
            .modo    (modo_ef),
            .dir     (dir_ef),
            .q_n     (q[i])
        );
    end

    assign s_out = (dir == DIR_DER) ? q[0] : q[WIDTH-1];

endmodule
